// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the two-port LED frame RAM arbiter: FSM states,
// port identifiers and the burst counter width.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } arb_state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Wide enough for MAX_BURST up to 255.
  localparam int CNT_W = 8;

endpackage

// File: rtl/ram_rd_tag_pipe.sv
// Two-stage read tag shift register: follows each issued read through the
// RAM's registered address and read stages and steers rvalid to its issuer.
module ram_rd_tag_pipe
  import ram_arbiter_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic i_vld,
  input  logic i_port,
  output logic o_a_rvalid,
  output logic o_b_rvalid
);

  logic r_vld_p0;
  logic r_port_p0;
  logic r_vld_p1;
  logic r_port_p1;

  // p0: address registered toward the RAM; p1: RAM read executed, data on dat_o
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p0 <= i_vld;
      r_vld_p1 <= r_vld_p0;
    end
    r_port_p0 <= i_port;
    r_port_p1 <= r_port_p0;
  end

  assign o_a_rvalid = r_vld_p1 && (r_port_p1 == PORT_A);
  assign o_b_rvalid = r_vld_p1 && (r_port_p1 == PORT_B);

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous frame RAM between
// the frame loader (A) and the LED refresh scanner (B), with bounded lock bursts.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic                  a_lock,
  input  logic [ADDR_WIDTH-1:0] a_adr,
  input  logic [DATA_WIDTH-1:0] a_wdat,
  output logic                  a_ack,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdat,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic                  b_lock,
  input  logic [ADDR_WIDTH-1:0] b_adr,
  input  logic [DATA_WIDTH-1:0] b_wdat,
  output logic                  b_ack,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdat,
  output logic                  ram_sel,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_adr,
  output logic [DATA_WIDTH-1:0] ram_dat_w,
  input  logic [DATA_WIDTH-1:0] ram_dat_r
);

  localparam logic [CNT_W-1:0] MAX_B = CNT_W'(MAX_BURST);

  arb_state_t       r_state;
  logic             r_rr_b;
  logic [CNT_W-1:0] r_cnt;

  logic w_grant_a;
  logic w_grant_b;
  logic w_keep;
  logic w_pref_b;
  logic w_both;
  logic w_win_we;

  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    w_keep    = 1'b0;
    w_pref_b  = r_rr_b;
    w_both    = a_req && b_req;
    case (r_state)
      ST_OWN_A:
        if (a_req && a_lock && (r_cnt < MAX_B)) begin
          w_grant_a = 1'b1;
          w_keep    = 1'b1;
        end else begin
          w_pref_b = 1'b1;
        end
      ST_OWN_B:
        if (b_req && b_lock && (r_cnt < MAX_B)) begin
          w_grant_b = 1'b1;
          w_keep    = 1'b1;
        end else begin
          w_pref_b = 1'b0;
        end
      default: ;
    endcase
    // A released owner falls through to the idle rules in the same cycle.
    if (!w_keep) begin
      if (w_both) begin
        w_grant_a = !w_pref_b;
        w_grant_b = w_pref_b;
      end else begin
        w_grant_a = a_req;
        w_grant_b = b_req;
      end
    end
    w_win_we = w_grant_b ? b_we : a_we;
  end

  assign a_ack  = w_grant_a && !reset;
  assign b_ack  = w_grant_b && !reset;
  assign a_rdat = ram_dat_r;
  assign b_rdat = ram_dat_r;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_rr_b  <= PORT_A;
      r_cnt   <= '0;
    end else if (w_keep) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_rr_b <= w_both ? !w_pref_b : w_pref_b;
      if (w_grant_a && a_lock) begin
        r_state <= ST_OWN_A;
        r_cnt   <= CNT_W'(1);
      end else if (w_grant_b && b_lock) begin
        r_state <= ST_OWN_B;
        r_cnt   <= CNT_W'(1);
      end else begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end
    end
  end

  // RAM strobes: registered from the winner of the current cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      ram_sel   <= 1'b0;
      ram_we    <= 1'b0;
      ram_adr   <= '0;
      ram_dat_w <= '0;
    end else if (w_grant_a || w_grant_b) begin
      ram_sel   <= 1'b1;
      ram_we    <= w_win_we;
      ram_adr   <= w_grant_b ? b_adr : a_adr;
      ram_dat_w <= w_grant_b ? b_wdat : a_wdat;
    end else begin
      ram_sel <= 1'b0;
      ram_we  <= 1'b0;
    end
  end

  ram_rd_tag_pipe u_tag (
    .clock      (clock),
    .reset      (reset),
    .i_vld      ((a_ack || b_ack) && !w_win_we),
    .i_port     (w_grant_b),
    .o_a_rvalid (a_rvalid),
    .o_b_rvalid (b_rvalid)
  );

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM
// (1-cycle read latency) attached to the ram_* strobes.
module tb_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic          a_req, a_we, a_lock;
  logic [AW-1:0] a_adr;
  logic [DW-1:0] a_wdat;
  logic          a_ack, a_rvalid;
  logic [DW-1:0] a_rdat;
  logic          b_req, b_we, b_lock;
  logic [AW-1:0] b_adr;
  logic [DW-1:0] b_wdat;
  logic          b_ack, b_rvalid;
  logic [DW-1:0] b_rdat;
  logic          ram_sel, ram_we;
  logic [AW-1:0] ram_adr;
  logic [DW-1:0] ram_dat_w;
  logic [DW-1:0] ram_dat_r;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [DW-1:0] PAT = 64'h0123_4567_89AB_CDEF;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_sel) begin
      if (ram_we) mem[ram_adr] <= ram_dat_w;
      else        ram_dat_r    <= mem[ram_adr];
    end
  end

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(8)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_adr(a_adr), .a_wdat(a_wdat),
    .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdat(a_rdat),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_adr(b_adr), .b_wdat(b_wdat),
    .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdat(b_rdat),
    .ram_sel(ram_sel), .ram_we(ram_we), .ram_adr(ram_adr),
    .ram_dat_w(ram_dat_w), .ram_dat_r(ram_dat_r)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    a_req = 0; a_we = 0; a_lock = 0; a_adr = '0; a_wdat = '0;
    b_req = 0; b_we = 0; b_lock = 0; b_adr = '0; b_wdat = '0;
    cyc();
    cyc();
    // Reset state, with requests present to prove acks are masked
    a_req = 1; b_req = 1;
    #1;
    chk("rst_a_ack", 64'(a_ack), 64'd0);
    chk("rst_b_ack", 64'(b_ack), 64'd0);
    chk("rst_sel", 64'(ram_sel), 64'd0);
    chk("rst_we", 64'(ram_we), 64'd0);
    chk("rst_adr", 64'(ram_adr), 64'd0);
    chk("rst_datw", ram_dat_w, 64'd0);
    chk("rst_rvalid", 64'({a_rvalid, b_rvalid}), 64'd0);
    cyc();

    // 1: single port write then read
    reset = 0; b_req = 0;
    a_req = 1; a_we = 1; a_adr = 4'd3; a_wdat = PAT;
    #1 chk("t1_wr_ack", 64'({a_ack, b_ack}), 64'b10);
    cyc();
    chk("t1_sel", 64'({ram_sel, ram_we}), 64'b11);
    chk("t1_adr", 64'(ram_adr), 64'd3);
    chk("t1_datw", ram_dat_w, PAT);
    a_we = 0;
    #1 chk("t1_rd_ack", 64'(a_ack), 64'd1);
    cyc();
    a_req = 0;
    #1 chk("t1_rv_early", 64'(a_rvalid), 64'd0);
    cyc();
    #1;
    chk("t1_rvalid", 64'(a_rvalid), 64'd1);
    chk("t1_rdat", a_rdat, PAT);
    chk("t1_b_rvalid", 64'(b_rvalid), 64'd0);
    cyc();
    chk("t1_rv_once", 64'(a_rvalid), 64'd0);

    // 2: contention, both read adr 3 continuously
    a_we = 0; b_we = 0; a_adr = 4'd3; b_adr = 4'd3;
    for (int k = 0; k < 8; k++) begin
      a_req = (k < 6); b_req = (k < 6);
      #1;
      chk($sformatf("t2_a_ack%0d", k), 64'(a_ack), 64'((k < 6) && (k % 2 == 0)));
      chk($sformatf("t2_b_ack%0d", k), 64'(b_ack), 64'((k < 6) && (k % 2 == 1)));
      if (k >= 2) begin
        chk($sformatf("t2_a_rv%0d", k), 64'(a_rvalid), 64'(k % 2 == 0));
        chk($sformatf("t2_b_rv%0d", k), 64'(b_rvalid), 64'(k % 2 == 1));
        chk($sformatf("t2_rdat%0d", k), a_rdat, PAT);
      end
      cyc();
    end

    // 3: A locks for 12 beats while B waits; burst capped at 8
    a_adr = 4'd0; b_adr = 4'd1; a_lock = 1;
    for (int k = 0; k < 13; k++) begin
      a_req = 1; b_req = (k <= 8);
      #1;
      chk($sformatf("t3_a_ack%0d", k), 64'(a_ack), 64'(k != 8));
      chk($sformatf("t3_b_ack%0d", k), 64'(b_ack), 64'(k == 8));
      cyc();
    end
    a_req = 0; b_req = 0; a_lock = 0;
    cyc();

    // 4: A locks for 3 beats then drops lock with B waiting
    for (int k = 0; k < 5; k++) begin
      a_req = 1; a_lock = (k < 3); b_req = (k >= 1 && k != 4) || (k == 4);
      #1;
      chk($sformatf("t4_a_ack%0d", k), 64'(a_ack), 64'(k != 3));
      chk($sformatf("t4_b_ack%0d", k), 64'(b_ack), 64'(k == 3));
      cyc();
    end
    a_req = 0; b_req = 0; a_lock = 0;
    cyc();

    // 5: B writes adr 15, A reads it on the following cycle
    b_req = 1; b_we = 1; b_adr = 4'd15; b_wdat = 64'hFF;
    #1 chk("t5_b_ack", 64'(b_ack), 64'd1);
    cyc();
    b_req = 0; b_we = 0;
    a_req = 1; a_we = 0; a_adr = 4'd15;
    #1 chk("t5_a_ack", 64'(a_ack), 64'd1);
    cyc();
    a_req = 0;
    cyc();
    #1;
    chk("t5_rvalid", 64'(a_rvalid), 64'd1);
    chk("t5_rdat", a_rdat, 64'hFF);
    cyc();

    // 6: reset in the cycle after an A read ack
    a_req = 1; a_we = 0; a_adr = 4'd3;
    #1 chk("t6_ack", 64'(a_ack), 64'd1);
    cyc();
    reset = 1; b_req = 1;
    #1;
    chk("t6_a_ack_rst", 64'(a_ack), 64'd0);
    chk("t6_b_ack_rst", 64'(b_ack), 64'd0);
    chk("t6_rv0", 64'(a_rvalid), 64'd0);
    cyc();
    reset = 0; a_req = 0; b_req = 0;
    #1;
    chk("t6_sel", 64'(ram_sel), 64'd0);
    chk("t6_rv1", 64'(a_rvalid), 64'd0);
    cyc();
    chk("t6_rv2", 64'({a_rvalid, b_rvalid}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
